and_mux_pattern_checker: RTL and testbench
==========================================

Name: and_mux_pattern_checker

Overview:
- Board-side stimulus generator and response checker for the and-mux example chip (pads a, b, s in; pad y out).
- Drives all 8 input combinations onto the chip's input pads and samples y after a fixed latency.
- Compares each sample against the golden function y = s ? b : (a & b).
- Mismatches flag routing tampering. Runs in the same clock domain as the harness that hosts the chip.

Parameters:
- LAT, 2, cycles between driving a vector and sampling y_i (min 1).
- ROUNDS, 4, number of full 8-vector sweeps per run (min 1).
- ERR_W, 8, width of the error counter (saturating).

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- a_o  out  1  drives chip pad a.
- b_o  out  1  drives chip pad b.
- s_o  out  1  drives chip pad s.
- y_i  in  1  chip pad y.
- busy  out  1  high while a run is active.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  valid from done until the next start; 1 iff err_count == 0.
- err_count  out  ERR_W  mismatches in the current/last run; saturates at all-ones.
- first_err_valid  out  1  a mismatch has occurred this run.
- first_err_vec  out  3  {s,b,a} of the first mismatching vector.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; vector counter 0; round counter 0; LAT counter 0.
- Vector order: vec[2:0] = {s,b,a}, counting 0..7.
  - a_o = vec[0], b_o = vec[1], s_o = vec[2], all registered.
  - Outputs hold their value between vectors and after the run ends.
- Golden response: exp = vec[2] ? vec[1] : (vec[0] & vec[1]). Expected ones occur at vec 3, 6, 7.
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
  - IDLE: on start, clear err_count, first_err_*, pass; vec = 0; round = 0; busy = 1; go to DRIVE. start is ignored in all other states.
  - DRIVE: pads are loaded with vec this cycle; load LAT counter with LAT-1; go to WAIT.
  - WAIT: decrement the LAT counter; at 0 go to CHECK. With LAT=1, WAIT lasts 1 cycle. y_i is sampled exactly LAT cycles after the DRIVE edge.
  - CHECK: compare y_i with exp.
    - On mismatch, err_count += 1 unless already saturated.
    - If first_err_valid is 0, set it and capture vec into first_err_vec.
    - Then vec += 1. On wrap 7->0, round += 1.
    - If round == ROUNDS-1 and vec == 7, go to DONE; otherwise go to DRIVE.
  - DONE: one cycle. done = 1; pass = (err_count == 0), using the count after the final CHECK; busy = 0; go to IDLE.
- Per-vector period is LAT+2 cycles. Total run length is 8*ROUNDS*(LAT+2)+1 cycles from the start edge to done.
- y_i that is X/Z is treated as a mismatch by the bench only; the RTL compares the 2-state value.
- Reset mid-run aborts immediately to the reset values above. No partial done.

Optional Feature:
- Macro AND_MUX_CHK_SYNC_EN.
- Defined: y_i passes through a 2-flop synchronizer before comparison, and the effective sample point becomes LAT+2 cycles after DRIVE. The WAIT load value becomes LAT+1, so the period is LAT+4 cycles.
- Undefined: y_i is compared directly, with timing as in Behaviour.

Decomposition:
- Package and_mux_chk_pkg:
  - state enum (IDLE, DRIVE, WAIT, CHECK, DONE);
  - VEC_W = 3;
  - function golden_y(vec) returning s ? b : (a & b).
- One sub-module: and_mux_chk_sync (2-flop synchronizer, reset to 0), instantiated only under AND_MUX_CHK_SYNC_EN.

Test Plan:
- Ideal model loopback (y_i = golden of a_o/b_o/s_o delayed LAT cycles), start pulse, defaults -> done after 8*4*4+1 = 129 cycles; pass = 1; err_count = 0; first_err_valid = 0.
- Model with y stuck-at-0 -> err_count = 12 (3 ones x 4 rounds); first_err_vec = 3'b011; pass = 0.
- Malicious model y = s ? a : (a&b) (a/b route swap) -> mismatches at vec 5 and 6 each round; err_count = 8; first_err_vec = 3'b101.
- ERR_W=2 with inverted y -> err_count saturates at 3; pass = 0.
- Assert rst_n low at cycle 40 of a run -> busy = 0, pads = 0, no done pulse. A new start afterwards gives a clean run with pass = 1.
- start held high for the full run plus a second start pulse while busy -> exactly one run and one done pulse; with AND_MUX_CHK_SYNC_EN, the run length is 8*4*6+1 = 193 cycles.

Source files
------------

// File: rtl/and_mux_chk_pkg.sv
// rtl/and_mux_chk_pkg.sv - shared types and golden model for the and-mux pattern checker
//
// Contents:
//   VEC_W     width of a test vector {s,b,a}
//   state_e   checker FSM states
//   golden_y  reference response of the and-mux chip for one vector
package and_mux_chk_pkg;

    localparam int VEC_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_e;

    // vec = {s,b,a}; the chip must produce s ? b : (a & b)
    function automatic logic golden_y(input logic [VEC_W-1:0] vec);
        return vec[2] ? vec[1] : (vec[0] & vec[1]);
    endfunction

endpackage

// File: rtl/and_mux_chk_sync.sv
// rtl/and_mux_chk_sync.sv - two-flop synchronizer for the chip response pad
//
// Ports:
//   clk    clock
//   rst_n  async active-low reset, both stages clear to 0
//   d_i    asynchronous input
//   q_o    synchronized output, two cycles behind d_i
module and_mux_chk_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/and_mux_pattern_checker.sv
// rtl/and_mux_pattern_checker.sv - stimulus generator and response checker for the and-mux chip
//
// Sweeps all 8 {s,b,a} vectors ROUNDS times, samples y after a fixed latency
// and counts responses that differ from s ? b : (a & b).
//
// Parameters:
//   LAT     cycles between driving a vector and sampling y_i (>= 1)
//   ROUNDS  full 8-vector sweeps per run (>= 1)
//   ERR_W   width of the saturating error counter
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start            pulse; launches a run when idle (a held level launches only one run)
//   a_o, b_o, s_o    registered chip pad drives, held between vectors and after the run
//   y_i              chip response pad
//   busy             high while a run is active
//   done             one-cycle pulse at run end
//   pass             valid from done until next start; 1 iff no mismatches
//   err_count        saturating mismatch count for the current/last run
//   first_err_valid  a mismatch has been seen this run
//   first_err_vec    {s,b,a} of the first mismatching vector
//
// Build option: AND_MUX_CHK_SYNC_EN routes y_i through a 2-flop synchronizer
// and stretches the wait by two cycles to cover it.
module and_mux_pattern_checker
    import and_mux_chk_pkg::*;
#(
    parameter int LAT    = 2,
    parameter int ROUNDS = 4,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    output logic             s_o,
    input  logic             y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [VEC_W-1:0] first_err_vec
);

`ifdef AND_MUX_CHK_SYNC_EN
    localparam int LAT_LOAD = LAT + 1;
`else
    localparam int LAT_LOAD = LAT - 1;
`endif
    localparam int CNT_W = $clog2(LAT + 2) + 1;
    localparam int RND_W = $clog2(ROUNDS) + 1;

    state_e             state_q;
    logic [VEC_W-1:0]   vec_q;
    logic [RND_W-1:0]   round_q;
    logic [CNT_W-1:0]   lat_q;
    logic               start_prev_q;
    logic [2:0]         pads_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [ERR_W-1:0]   err_q;
    logic               fev_q;
    logic [VEC_W-1:0]   fvec_q;

    logic               y_cmp;
    logic               start_rise;
    logic               last_vec;

`ifdef AND_MUX_CHK_SYNC_EN
    and_mux_chk_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (y_i),
        .q_o   (y_cmp)
    );
`else
    assign y_cmp = y_i;
`endif

    // Edge-qualified so that a start level held across run end cannot relaunch
    assign start_rise = start & ~start_prev_q;
    assign last_vec   = (round_q == RND_W'(ROUNDS - 1)) && (vec_q == VEC_W'(7));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev_q <= 1'b0;
        end else begin
            start_prev_q <= start;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            round_q <= '0;
            lat_q   <= '0;
            pads_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fvec_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_rise) begin
                        err_q   <= '0;
                        fev_q   <= 1'b0;
                        fvec_q  <= '0;
                        pass_q  <= 1'b0;
                        vec_q   <= '0;
                        round_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    pads_q  <= vec_q;
                    lat_q   <= CNT_W'(LAT_LOAD);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (lat_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                CHECK: begin
                    if (y_cmp != golden_y(vec_q)) begin
                        if (err_q != {ERR_W{1'b1}}) begin
                            err_q <= err_q + 1'b1;
                        end
                        if (!fev_q) begin
                            fev_q  <= 1'b1;
                            fvec_q <= vec_q;
                        end
                    end
                    vec_q <= vec_q + 1'b1;
                    if (vec_q == VEC_W'(7)) begin
                        round_q <= round_q + 1'b1;
                    end
                    state_q <= last_vec ? DONE : DRIVE;
                end
                DONE: begin
                    // err_q already includes the final CHECK's update here
                    done_q  <= 1'b1;
                    pass_q  <= (err_q == '0);
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_o             = pads_q[0];
    assign b_o             = pads_q[1];
    assign s_o             = pads_q[2];
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fvec_q;

endmodule

// File: tb/tb_and_mux_pattern_checker.sv
// tb/tb_and_mux_pattern_checker.sv - self-checking bench for and_mux_pattern_checker
`timescale 1ns/1ps
module tb_and_mux_pattern_checker;

`ifdef AND_MUX_CHK_SYNC_EN
    localparam int PERIOD = 6;
`else
    localparam int PERIOD = 4;
`endif
    localparam int RUN_CYC = 8 * 4 * PERIOD + 1;
    localparam logic [7:0] GOLD = 8'b1100_1000;

    typedef struct {
        int mode;
        int pass;
        int err;
        int fev;
        int fvec;
    } rec_t;

    typedef struct {
        int pass;
        int err;
        int fev;
        int fvec;
        int cyc;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start_sat;
    logic       a_o, b_o, s_o, y_i, busy, done, pass, fev;
    logic [7:0] err_count;
    logic [2:0] fvec;
    logic       a2, b2, s2, y2, busy2, done2, pass2, fev2;
    logic [1:0] err2;
    logic [2:0] fvec2;

    int   mode;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_start = 0;
    int   done_cnt = 0;
    logic [1:0] pipe  = '0;
    logic [1:0] pipe2 = '0;
    rec_t exp_q[$];
    obs_t obs_q[$];
    rec_t tbl[4];

    always #5 clk = ~clk;

    and_mux_pattern_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_o(a_o), .b_o(b_o), .s_o(s_o), .y_i(y_i),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_valid(fev), .first_err_vec(fvec)
    );

    and_mux_pattern_checker #(.ERR_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_sat),
        .a_o(a2), .b_o(b2), .s_o(s2), .y_i(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_valid(fev2), .first_err_vec(fvec2)
    );

    // chip model: 0 ideal, 1 stuck-at-0, 2 a/b swapped on s=1, 3 inverted
    function automatic logic model_y(input int m, input logic [2:0] v);
        logic [7:0] g;
        g = GOLD;
        case (m)
            0:       return g[v];
            1:       return 1'b0;
            2:       return v[2] ? v[0] : (v[0] & v[1]);
            default: return ~g[v];
        endcase
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pipe  <= {pipe[0], model_y(mode, {s_o, b_o, a_o})};
        pipe2 <= {pipe2[0], model_y(3, {s2, b2, a2})};
    end
    assign y_i = pipe[1];
    assign y2  = pipe2[1];

    always @(negedge clk) begin
        if (done) begin
            obs_q.push_back('{int'(pass), int'(err_count), int'(fev), int'(fvec), cyc - t_start});
            done_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input int d0, input string name);
        int n;
        n = 0;
        while (done_cnt == d0 && n < RUN_CYC + 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, int'(done_cnt != d0), 1);
    endtask

    task automatic compare_one(input string name);
        rec_t e;
        obs_t o;
        check({name, "_result_present"}, int'(exp_q.size() != 0 && obs_q.size() != 0), 1);
        if (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({name, "_pass"}, o.pass, e.pass);
            check({name, "_err_count"}, o.err, e.err);
            check({name, "_first_err_valid"}, o.fev, e.fev);
            check({name, "_first_err_vec"}, o.fvec, e.fvec);
            check({name, "_run_cycles"}, o.cyc, RUN_CYC);
        end
    endtask

    task automatic launch(input rec_t r);
        mode = r.mode;
        exp_q.push_back(r);
        start = 1'b1;
        @(posedge clk);
        #1 t_start = cyc;
        @(negedge clk);
    endtask

    task automatic run_rec(input rec_t r, input string name);
        int d0;
        d0 = done_cnt;
        launch(r);
        start = 1'b0;
        wait_done(d0, name);
        compare_one(name);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; start_sat = 1'b0; mode = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_first_err_valid", int'(fev), 0);
        check("rst_first_err_vec", int'(fvec), 0);
        check("rst_pads", int'({s_o, b_o, a_o}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        tbl[0] = '{0, 1, 0, 0, 0};
        tbl[1] = '{1, 0, 12, 1, 3};
        tbl[2] = '{2, 0, 8, 1, 5};
        tbl[3] = '{0, 1, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            run_rec(tbl[i], $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_busy_after", i), int'(busy), 0);
            check($sformatf("tbl%0d_pads_hold", i), int'({s_o, b_o, a_o}), 7);
        end

        // reset in the middle of a run
        mode = 0;
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_pads", int'({s_o, b_o, a_o}), 0);
        check("midrst_err_count", int'(err_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (RUN_CYC + 20) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_no_result", obs_q.size(), 0);
        run_rec('{0, 1, 0, 0, 0}, "post_rst");

        // start held high through the run, with an extra rising edge while busy
        d0 = done_cnt;
        launch('{0, 1, 0, 0, 0});
        repeat (60) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        wait_done(d0, "held");
        repeat (5) @(negedge clk);
        start = 1'b0;
        repeat (RUN_CYC / 2) @(negedge clk);
        check("held_one_done", done_cnt - d0, 1);
        check("held_idle", int'(busy), 0);
        compare_one("held");

        // ERR_W=2 instance against an inverting chip saturates
        start_sat = 1'b1;
        @(negedge clk);
        start_sat = 1'b0;
        d0 = 0;
        while (!done2 && d0 < RUN_CYC + 50) begin
            @(negedge clk);
            d0++;
        end
        check("sat_done_seen", int'(done2), 1);
        check("sat_err_count", int'(err2), 3);
        check("sat_pass", int'(pass2), 0);
        check("sat_first_err_vec", int'(fvec2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
